vdp_cpu_port: RTL and testbench

//  Parametrised CPU-side port of the VDP: the next generation of the TMS9918-style #98/#99 logic.

---
 rtl/vdp_pkg.sv | 53 +++++
 rtl/vdp_palette.sv | 57 +++++
 rtl/vdp_cpu_port.sv | 273 +++++++++++++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU port: port codes, status bit positions,
// control-port state enum, register index constants and the power-on palette.
package vdp_pkg;

    // CPU I/O port codes (#98..#9B)
    localparam logic [1:0] PORT_DATA  = 2'd0;
    localparam logic [1:0] PORT_CTRL  = 2'd1;
    localparam logic [1:0] PORT_PAL   = 2'd2;
    localparam logic [1:0] PORT_INDIR = 2'd3;

    // Status register S#0 bit positions
    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    // Register indices with special meaning inside the port
    localparam logic [5:0] R1_IDX  = 6'd1;
    localparam logic [5:0] R14_IDX = 6'd14;
    localparam logic [5:0] R15_IDX = 6'd15;
    localparam logic [5:0] R16_IDX = 6'd16;
    localparam logic [5:0] R17_IDX = 6'd17;

    // Two-byte sequencing state of the #99 control port
    typedef enum logic {
        CTL_FIRST  = 1'b0,
        CTL_SECOND = 1'b1
    } ctl_state_t;

    // Power-on colour table, {R3,G3,B3}
    function automatic logic [8:0] default_pal(input logic [3:0] idx);
        logic [8:0] rgb;
        case (idx)
            4'd0:    rgb = 9'h000;
            4'd1:    rgb = 9'h000;
            4'd2:    rgb = 9'h071;
            4'd3:    rgb = 9'h0FB;
            4'd4:    rgb = 9'h04F;
            4'd5:    rgb = 9'h09F;
            4'd6:    rgb = 9'h149;
            4'd7:    rgb = 9'h0B7;
            4'd8:    rgb = 9'h1C9;
            4'd9:    rgb = 9'h1DB;
            4'd10:   rgb = 9'h1B1;
            4'd11:   rgb = 9'h1B4;
            4'd12:   rgb = 9'h061;
            4'd13:   rgb = 9'h195;
            4'd14:   rgb = 9'h16D;
            default: rgb = 9'h1FF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vdp_palette.sv
// Writable 16-entry palette: #9A takes two bytes {0RRR0BBB},{00000GGG} per entry.
// Only built when VDP_PALETTE_EN is defined.
module vdp_palette
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wdata,
    input  logic [3:0] entry,
    input  logic       tog_clr,
    input  logic [3:0] pal_idx,
    output logic [8:0] pal_rgb,
    output logic       pal_inc
);

    logic [8:0] mem_reg [16];
    logic       tog_reg;
    logic [7:0] lat_reg;
    logic [8:0] rgb_reg;

    // Byte toggle; first byte (red/blue) is held until green arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_reg <= 1'b0;
            lat_reg <= '0;
        end else if (tog_clr) begin
            tog_reg <= 1'b0;
        end else if (wr_en) begin
            tog_reg <= ~tog_reg;
            if (!tog_reg) lat_reg <= wdata;
        end
    end

    // Entries reset to the power-on colours; written when the second byte lands
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset)
                    mem_reg[gi] <= default_pal(4'(gi));
                else if (wr_en && tog_reg && entry == 4'(gi))
                    mem_reg[gi] <= {lat_reg[6:4], wdata[2:0], lat_reg[2:0]};
            end
        end
    endgenerate

    // Registered lookup for the video side
    always_ff @(posedge clk) begin
        if (reset) rgb_reg <= '0;
        else       rgb_reg <= mem_reg[pal_idx];
    end

    assign pal_rgb = rgb_reg;
    assign pal_inc = wr_en & tog_reg;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: #98 data, #99 control/status, #9A palette, #9B indirect.
// Holds the register file and sticky status flags and drives a req/ack VRAM master
// with read-ahead buffer and auto-increment. Optional feature macro: VDP_PALETTE_EN.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int VRAM_AW    = 14,
    parameter int NUM_STATUS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic [1:0]            io_port,
    input  logic [7:0]            io_din,
    output logic [7:0]            io_dout,
    output logic                  wait_n,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  vram_req,
    output logic                  vram_we,
    input  logic                  vram_ack,
    input  logic [7:0]            vram_rdata,
    input  logic                  frame_irq,
    input  logic                  collision,
    input  logic [4:0]            spr5,
    input  logic                  spr5_flag,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  n_int,
    input  logic [3:0]            pal_idx,
    output logic [8:0]            pal_rgb
);

    localparam logic [6:0] NREGS7   = 7'(NUM_REGS);
    localparam bit         INDIR_OK = (NUM_REGS >= 18);

    logic [7:0]  regs_reg [NUM_REGS];
    ctl_state_t  ctl_state_reg, ctl_state_next;
    logic [7:0]  byte0_reg, byte0_next;
    logic [13:0] addr_reg;
    logic [7:0]  rbuf_reg, wdata_reg;
    logic        req_reg, we_reg, f_reg, c_reg;

    logic        accept, wr_acc, rd_acc;
    logic        cw_reg_we, cw_addr_load, cw_prefetch;
    logic        reg_we, r17_inc, r14_carry, pal_inc, s0_read;
    logic [5:0]  reg_widx;
    logic [7:0]  reg_wdata, status0, status_rd, r17;
    logic        r1_ie;
    logic [2:0]  r14_hi;
    logic [3:0]  r15_lo;

    // A request in flight stalls the CPU; anything it sends meanwhile is dropped
    assign accept = ~req_reg;
    assign wr_acc = io_wr & accept;
    assign rd_acc = io_rd & accept;

    // Taps on registers the port itself interprets
    assign r1_ie = regs_reg[1][5];
    generate
        if (VRAM_AW == 17 && NUM_REGS > 14) begin : g_r14
            assign r14_hi = regs_reg[14][2:0];
        end else begin : g_no_r14
            assign r14_hi = '0;
        end
        if (NUM_STATUS > 1 && NUM_REGS > 15) begin : g_r15
            assign r15_lo = regs_reg[15][3:0];
        end else begin : g_no_r15
            assign r15_lo = '0;
        end
        if (NUM_REGS > 17) begin : g_r17
            assign r17 = regs_reg[17];
        end else begin : g_no_r17
            assign r17 = '0;
        end
    endgenerate

    // Control port byte sequencing state
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_state_reg <= CTL_FIRST;
            byte0_reg     <= '0;
        end else begin
            ctl_state_reg <= ctl_state_next;
            byte0_reg     <= byte0_next;
        end
    end

    // Control port next state and decode of the second byte
    always_comb begin
        ctl_state_next = ctl_state_reg;
        byte0_next     = byte0_reg;
        cw_reg_we      = 1'b0;
        cw_addr_load   = 1'b0;
        cw_prefetch    = 1'b0;
        if (wr_acc && io_port == PORT_CTRL) begin
            if (ctl_state_reg == CTL_FIRST) begin
                byte0_next     = io_din;
                ctl_state_next = CTL_SECOND;
            end else begin
                ctl_state_next = CTL_FIRST;
                if (io_din[7]) begin
                    cw_reg_we = 1'b1;
                end else begin
                    cw_addr_load = 1'b1;
                    cw_prefetch  = ~io_din[6];
                end
            end
        end else if (((wr_acc || rd_acc) && io_port == PORT_DATA) ||
                     (rd_acc && io_port == PORT_CTRL)) begin
            ctl_state_next = CTL_FIRST;
        end
    end

    // Single register write port shared by #99 register writes and #9B
    always_comb begin
        reg_we    = 1'b0;
        reg_widx  = '0;
        reg_wdata = '0;
        r17_inc   = 1'b0;
        if (cw_reg_we) begin
            reg_widx  = io_din[5:0];
            reg_wdata = byte0_reg;
            reg_we    = ({1'b0, io_din[5:0]} < NREGS7);
        end else if (INDIR_OK && wr_acc && io_port == PORT_INDIR &&
                     {1'b0, r17[5:0]} < NREGS7) begin
            reg_widx  = r17[5:0];
            reg_wdata = io_din;
            reg_we    = 1'b1;
            r17_inc   = ~r17[7];
        end
    end

    // Address carry into R14 when the 14-bit counter rolls over (128 KB mode)
    assign r14_carry = (VRAM_AW == 17) && req_reg && vram_ack && (addr_reg == 14'h3FFF);

    // Register file; a direct write beats the auto-increment side effects
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset)
                    regs_reg[gi] <= '0;
                else if (reg_we && reg_widx == 6'(gi))
                    regs_reg[gi] <= reg_wdata;
                else if (gi == 14 && r14_carry)
                    regs_reg[gi] <= {regs_reg[gi][7:3], regs_reg[gi][2:0] + 3'd1};
                else if (gi == 16 && pal_inc)
                    regs_reg[gi] <= {regs_reg[gi][7:4], regs_reg[gi][3:0] + 4'd1};
                else if (gi == 17 && r17_inc)
                    regs_reg[gi] <= {regs_reg[gi][7:6], regs_reg[gi][5:0] + 6'd1};
            end
            assign regs[gi*8 +: 8] = regs_reg[gi];
        end
    endgenerate

    // VRAM master: launch on an accepted access, retire on ack with post-increment
    always_ff @(posedge clk) begin
        if (reset) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            addr_reg  <= '0;
            rbuf_reg  <= '0;
        end else if (req_reg) begin
            if (vram_ack) begin
                req_reg  <= 1'b0;
                addr_reg <= addr_reg + 14'd1;
                if (!we_reg) rbuf_reg <= vram_rdata;
            end
        end else if (wr_acc && io_port == PORT_DATA) begin
            req_reg   <= 1'b1;
            we_reg    <= 1'b1;
            wdata_reg <= io_din;
        end else if (rd_acc && io_port == PORT_DATA) begin
            req_reg <= 1'b1;
            we_reg  <= 1'b0;
        end else if (cw_addr_load) begin
            addr_reg <= {io_din[5:0], byte0_reg};
            if (cw_prefetch) begin
                req_reg <= 1'b1;
                we_reg  <= 1'b0;
            end
        end
    end

    generate
        if (VRAM_AW == 17) begin : g_addr17
            assign vram_addr = {r14_hi, addr_reg};
        end else begin : g_addr14
            assign vram_addr = addr_reg;
        end
    endgenerate

    // Reset removes the request immediately rather than a cycle later
    assign vram_req   = req_reg & ~reset;
    assign vram_we    = we_reg;
    assign vram_wdata = wdata_reg;
    assign wait_n     = ~vram_req;

    // Status read mux; only S#0 is implemented here
    always_comb begin
        status0            = '0;
        status0[ST_F]      = f_reg;
        status0[ST_5S]     = spr5_flag;
        status0[ST_C]      = c_reg;
        status0[4:0]       = spr5_flag ? spr5 : 5'h1F;
        status_rd          = (r15_lo == 4'd0) ? status0 : 8'h00;
    end

    assign s0_read = rd_acc && io_port == PORT_CTRL && r15_lo == 4'd0;

    // Sticky flags: a set pulse wins over a clearing read in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            f_reg <= 1'b0;
            c_reg <= 1'b0;
        end else begin
            f_reg <= (f_reg & ~s0_read) | frame_irq;
            c_reg <= (c_reg & ~s0_read) | collision;
        end
    end

    // CPU read data, valid only during the read strobe
    always_comb begin
        io_dout = 8'h00;
        if (io_rd) begin
            case (io_port)
                PORT_DATA: io_dout = rbuf_reg;
                PORT_CTRL: io_dout = status_rd;
                default:   io_dout = 8'h00;
            endcase
        end
    end

    assign n_int = ~(f_reg & r1_ie);

`ifdef VDP_PALETTE_EN
    logic [3:0] r16_lo;
    generate
        if (NUM_REGS > 16) begin : g_r16
            assign r16_lo = regs_reg[16][3:0];
        end else begin : g_no_r16
            assign r16_lo = '0;
        end
    endgenerate

    vdp_palette u_palette (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc && io_port == PORT_PAL),
        .wdata   (io_din),
        .entry   (r16_lo),
        .tog_clr (reg_we && reg_widx == R16_IDX),
        .pal_idx (pal_idx),
        .pal_rgb (pal_rgb),
        .pal_inc (pal_inc)
    );
`else
    logic [8:0] pal_rgb_reg;

    // Fixed colour table lookup, same one-cycle latency as the RAM version
    always_ff @(posedge clk) begin
        if (reset) pal_rgb_reg <= '0;
        else       pal_rgb_reg <= default_pal(pal_idx);
    end

    assign pal_rgb = pal_rgb_reg;
    assign pal_inc = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port (NUM_REGS=24, VRAM_AW=14, NUM_STATUS=1)
// with a small VRAM model that acks every request after a few cycles.
module tb_vdp_cpu_port;

    localparam int NR = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_wr, io_rd;
    logic [1:0]    io_port;
    logic [7:0]    io_din, io_dout;
    logic          wait_n;
    logic [13:0]   vram_addr;
    logic [7:0]    vram_wdata, vram_rdata;
    logic          vram_req, vram_we, vram_ack;
    logic          frame_irq, collision, spr5_flag;
    logic [4:0]    spr5;
    logic [NR*8-1:0] regs;
    logic          n_int;
    logic [3:0]    pal_idx;
    logic [8:0]    pal_rgb;

    int errors = 0;
    int checks = 0;

    logic [7:0]    mem [16384];
    logic [1:0]    lat_cnt;
    logic          pl_we;
    logic [13:0]   pl_addr;
    logic [7:0]    pl_data;
    logic [NR*8-1:0] exp_regs;

    always #5 clk = ~clk;

    vdp_cpu_port #(.NUM_REGS(NR), .VRAM_AW(14), .NUM_STATUS(1)) dut (
        .clk(clk), .reset(reset), .io_wr(io_wr), .io_rd(io_rd), .io_port(io_port),
        .io_din(io_din), .io_dout(io_dout), .wait_n(wait_n), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_req(vram_req), .vram_we(vram_we),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .frame_irq(frame_irq),
        .collision(collision), .spr5(spr5), .spr5_flag(spr5_flag), .regs(regs),
        .n_int(n_int), .pal_idx(pal_idx), .pal_rgb(pal_rgb)
    );

    // VRAM model: ack three cycles after the request appears
    always @(posedge clk) begin
        vram_ack <= 1'b0;
        if (pl_we) mem[pl_addr] <= pl_data;
        if (!vram_req) begin
            lat_cnt <= 2'd0;
        end else if (!vram_ack) begin
            if (lat_cnt == 2'd2) begin
                vram_ack <= 1'b1;
                lat_cnt  <= 2'd0;
                if (vram_we) mem[vram_addr] <= vram_wdata;
                else         vram_rdata     <= mem[vram_addr];
            end else begin
                lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end

    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_we = 1'b0;
    endtask

    task automatic io_write(input logic [1:0] p, input logic [7:0] d);
        @(negedge clk); io_wr = 1'b1; io_port = p; io_din = d;
        @(negedge clk); io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [1:0] p, output logic [7:0] d);
        @(negedge clk); io_rd = 1'b1; io_port = p;
        #1 d = io_dout;
        @(negedge clk); io_rd = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (wait_n !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL timeout_%s wait_n stuck at %b", tag, wait_n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pal_idx = 4'd2;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wait_n !== 1'b1 || vram_req !== 1'b0) begin errors++; $display("FAIL rst_wait got wait_n=%b req=%b exp 1/0", wait_n, vram_req); end
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL rst_nint got %b exp 1", n_int); end
        checks++; if (regs !== '0) begin errors++; $display("FAIL rst_regs got %h exp 0", regs); end
        checks++; if (vram_addr !== 14'h0 || io_dout !== 8'h00) begin errors++; $display("FAIL rst_addr got addr=%h dout=%h exp 0/0", vram_addr, io_dout); end
        checks++; if (pal_rgb !== 9'h071) begin errors++; $display("FAIL rst_pal2 got %h exp 071", pal_rgb); end
    endtask

    task automatic test_vram_write();
        io_write(2'd1, 8'h00);
        io_write(2'd1, 8'h40);
        checks++; if (wait_n !== 1'b1 || vram_addr !== 14'h0) begin errors++; $display("FAIL wsetup got wait_n=%b addr=%h exp 1/0000", wait_n, vram_addr); end
        io_write(2'd0, 8'hAA);
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL wr_wait0 got %b exp 0", wait_n); end
        io_write(2'd0, 8'hCC);   // dropped: CPU should have been stalled
        wait_idle("wr0");
        checks++; if (vram_addr !== 14'h1) begin errors++; $display("FAIL wr_addr1 got %h exp 0001", vram_addr); end
        io_write(2'd0, 8'hBB);
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL wr_wait1 got %b exp 0", wait_n); end
        wait_idle("wr1");
        checks++; if (mem[0] !== 8'hAA || mem[1] !== 8'hBB) begin errors++; $display("FAIL wr_mem got %h %h exp AA BB", mem[0], mem[1]); end
        checks++; if (vram_addr !== 14'h2) begin errors++; $display("FAIL wr_addr2 got %h exp 0002", vram_addr); end
    endtask

    task automatic test_read_wrap();
        logic [7:0] d;
        preload(14'h3FFF, 8'h5A);
        preload(14'h0000, 8'hC3);
        io_write(2'd1, 8'hFF);
        io_write(2'd1, 8'h3F);
        checks++; if (wait_n !== 1'b0 || vram_we !== 1'b0) begin errors++; $display("FAIL pf_req got wait_n=%b we=%b exp 0/0", wait_n, vram_we); end
        wait_idle("pf");
        checks++; if (vram_addr !== 14'h0) begin errors++; $display("FAIL pf_wrap got %h exp 0000", vram_addr); end
        io_read(2'd0, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd0 got %h exp 5A", d); end
        wait_idle("rd0");
        io_read(2'd0, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd1 got %h exp C3", d); end
        wait_idle("rd1");
        checks++; if (vram_addr !== 14'h2) begin errors++; $display("FAIL rd_addr got %h exp 0002", vram_addr); end
    endtask

    task automatic test_registers();
        logic [7:0] d;
        io_write(2'd1, 8'hF0);
        io_write(2'd1, 8'h87);
        exp_regs[7*8 +: 8] = 8'hF0;
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL r7 got %h exp %h", regs, exp_regs); end
        io_write(2'd1, 8'h12);
        io_write(2'd1, 8'hBF);
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL r63_ignored got %h exp %h", regs, exp_regs); end
        io_write(2'd1, 8'h55);
        io_read(2'd1, d);
        checks++; if (d !== 8'h1F) begin errors++; $display("FAIL st_idle got %h exp 1F", d); end
        io_write(2'd1, 8'h11);
        io_write(2'd1, 8'h81);
        exp_regs[1*8 +: 8] = 8'h11;
        checks++; if (regs !== exp_regs || wait_n !== 1'b1) begin errors++; $display("FAIL toggle_reset got %h wait_n=%b exp %h 1", regs, wait_n, exp_regs); end
    endtask

    task automatic test_status();
        logic [7:0] d;
        io_write(2'd1, 8'h20);
        io_write(2'd1, 8'h81);
        exp_regs[1*8 +: 8] = 8'h20;
        @(negedge clk); frame_irq = 1'b1;
        @(negedge clk); frame_irq = 1'b0;
        checks++; if (n_int !== 1'b0) begin errors++; $display("FAIL irq_low got %b exp 0", n_int); end
        spr5_flag = 1'b1; spr5 = 5'd5;
        io_read(2'd1, d);
        checks++; if (d !== 8'hC5) begin errors++; $display("FAIL st_f got %h exp C5", d); end
        checks++; if (n_int !== 1'b1) begin errors++; $display("FAIL irq_clr got %b exp 1", n_int); end
        io_read(2'd1, d);
        checks++; if (d !== 8'h45) begin errors++; $display("FAIL st_fclr got %h exp 45", d); end
        spr5_flag = 1'b0;
        @(negedge clk); collision = 1'b1;
        @(negedge clk); collision = 1'b0;
        io_read(2'd1, d);
        checks++; if (d !== 8'h3F) begin errors++; $display("FAIL st_c got %h exp 3F", d); end
        io_read(2'd1, d);
        checks++; if (d !== 8'h1F) begin errors++; $display("FAIL st_cclr got %h exp 1F", d); end
        @(negedge clk); io_rd = 1'b1; io_port = 2'd1; frame_irq = 1'b1;
        #1 d = io_dout;
        @(negedge clk); io_rd = 1'b0; frame_irq = 1'b0;
        checks++; if (d !== 8'h1F || n_int !== 1'b0) begin errors++; $display("FAIL st_coinc got %h n_int=%b exp 1F 0", d, n_int); end
        io_read(2'd1, d);
        checks++; if (d !== 8'h9F) begin errors++; $display("FAIL st_kept got %h exp 9F", d); end
        io_read(2'd1, d);
    endtask

    task automatic test_indirect();
        io_write(2'd1, 8'h02); io_write(2'd1, 8'h91);
        io_write(2'd3, 8'h11); io_write(2'd3, 8'h22);
        exp_regs[2*8 +: 8] = 8'h11; exp_regs[3*8 +: 8] = 8'h22; exp_regs[17*8 +: 8] = 8'h04;
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL indir_inc got %h exp %h", regs, exp_regs); end
        io_write(2'd1, 8'h82); io_write(2'd1, 8'h91);
        io_write(2'd3, 8'h33); io_write(2'd3, 8'h44);
        exp_regs[2*8 +: 8] = 8'h44; exp_regs[17*8 +: 8] = 8'h82;
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL indir_hold got %h exp %h", regs, exp_regs); end
        io_write(2'd1, 8'h1E); io_write(2'd1, 8'h91);
        io_write(2'd3, 8'h55);
        exp_regs[17*8 +: 8] = 8'h1E;
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL indir_oob got %h exp %h", regs, exp_regs); end
    endtask

    task automatic test_palette();
        io_write(2'd1, 8'h0F); io_write(2'd1, 8'h90);
        exp_regs[16*8 +: 8] = 8'h0F;
        pal_idx = 4'd15;
        io_write(2'd2, 8'h70); io_write(2'd2, 8'h07);
        repeat (2) @(negedge clk);
`ifdef VDP_PALETTE_EN
        exp_regs[16*8 +: 8] = 8'h00;
        checks++; if (pal_rgb !== 9'h1F8) begin errors++; $display("FAIL pal15 got %h exp 1F8", pal_rgb); end
`else
        checks++; if (pal_rgb !== 9'h1FF) begin errors++; $display("FAIL pal15 got %h exp 1FF", pal_rgb); end
`endif
        checks++; if (regs !== exp_regs) begin errors++; $display("FAIL pal_r16 got %h exp %h", regs, exp_regs); end
        pal_idx = 4'd3;
        repeat (2) @(negedge clk);
        checks++; if (pal_rgb !== 9'h0FB) begin errors++; $display("FAIL pal3 got %h exp 0FB", pal_rgb); end
    endtask

    task automatic test_reset_midreq();
        @(negedge clk); io_wr = 1'b1; io_port = 2'd0; io_din = 8'h77;
        @(negedge clk); io_wr = 1'b0; reset = 1'b1;
        #1;
        checks++; if (vram_req !== 1'b0 || wait_n !== 1'b1) begin errors++; $display("FAIL rst_drop got req=%b wait_n=%b exp 0/1", vram_req, wait_n); end
        @(negedge clk); reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (regs !== '0 || vram_addr !== 14'h0 || vram_req !== 1'b0) begin errors++; $display("FAIL rst_mid got regs=%h addr=%h req=%b exp 0", regs, vram_addr, vram_req); end
    endtask

    initial begin
        reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_port = 2'd0; io_din = 8'h00;
        frame_irq = 1'b0; collision = 1'b0; spr5 = 5'd0; spr5_flag = 1'b0;
        pal_idx = 4'd0; pl_we = 1'b0; pl_addr = '0; pl_data = '0; exp_regs = '0;
        test_reset();
        test_vram_write();
        test_read_wrap();
        test_registers();
        test_status();
        test_indirect();
        test_palette();
        test_reset_midreq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
